vga_timing_gen: RTL

Parametrised VGA raster timing generator that replaces the fixed 640x480 sync block in the display path of the Basys3 designs. It divides the board clock down to the pixel rate internally, generates pixel and line counters, and produces configurable-polarity sync signals and an active-video flag. It also provides line/frame strobes and a frame counter for game-logic pacing. All outputs are registered and mutually aligned, so renderers can use them without extra skew compensation.

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v position counters,
// and a registered, mutually aligned output stage (syncs, active flag, strobes, frame count).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               enable,
  output logic [CW-1:0]      xcount,
  output logic [CW-1:0]      ycount,
  output logic               displayArea,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic          HS_ON    = (H_POL != 0);
  localparam logic          VS_ON    = (V_POL != 0);

  // Half-open window test done in int so an end bound equal to 2^CW still compares correctly.
  function automatic logic in_window(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  logic [DW-1:0] div_cnt;
  logic          pix_tick;
  logic [CW-1:0] h_cnt_p0;
  logic [CW-1:0] v_cnt_p0;
  logic          h_wrap_p0;
  logic          v_wrap_p0;

  assign pix_tick = enable && (div_cnt == DIV_LAST);

  // Stage p0: divider and raster position; wrap flags mark the edge a counter returned to 0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      h_cnt_p0  <= '0;
      v_cnt_p0  <= '0;
      h_wrap_p0 <= 1'b0;
      v_wrap_p0 <= 1'b0;
    end else begin
      h_wrap_p0 <= 1'b0;
      v_wrap_p0 <= 1'b0;
      if (enable) begin
        div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      end
      if (pix_tick) begin
        if (h_cnt_p0 == H_LAST) begin
          h_cnt_p0  <= '0;
          h_wrap_p0 <= 1'b1;
          if (v_cnt_p0 == V_LAST) begin
            v_cnt_p0  <= '0;
            v_wrap_p0 <= 1'b1;
          end else begin
            v_cnt_p0 <= v_cnt_p0 + 1'b1;
          end
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: every output registered from the same p0 state, so all are mutually aligned.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      xcount      <= '0;
      ycount      <= '0;
      displayArea <= 1'b0;
      vga_hsync   <= ~HS_ON;
      vga_vsync   <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      xcount      <= h_cnt_p0;
      ycount      <= v_cnt_p0;
      displayArea <= in_window(int'(h_cnt_p0), 0, H_ACTIVE) &&
                     in_window(int'(v_cnt_p0), 0, V_ACTIVE);
      vga_hsync   <= in_window(int'(h_cnt_p0), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)
                     ? HS_ON : ~HS_ON;
      vga_vsync   <= in_window(int'(v_cnt_p0), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)
                     ? VS_ON : ~VS_ON;
      line_start  <= h_wrap_p0;
      frame_start <= v_wrap_p0;
      if (v_wrap_p0) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
